// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_pkg                                                  |
// | Shared op codes, types and FSM encodings for the load/store unit.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package load_store_unit_pkg;

    typedef logic [5:0]  OP_ENUM_TYPE;
    typedef logic [31:0] DATA_TYPE;
    typedef logic [31:0] ADDR_TYPE;
    typedef logic [4:0]  ROB_ID_TYPE;

    localparam ROB_ID_TYPE ROB_ID_RESET = 5'd0;

    localparam OP_ENUM_TYPE LB  = 6'd11;
    localparam OP_ENUM_TYPE LH  = 6'd12;
    localparam OP_ENUM_TYPE LW  = 6'd13;
    localparam OP_ENUM_TYPE LBU = 6'd14;
    localparam OP_ENUM_TYPE LHU = 6'd15;
    localparam OP_ENUM_TYPE SB  = 6'd16;
    localparam OP_ENUM_TYPE SH  = 6'd17;
    localparam OP_ENUM_TYPE SW  = 6'd18;

    localparam logic READ_SIT  = 1'b0;
    localparam logic WRITE_SIT = 1'b1;
    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;

    localparam ADDR_TYPE RAM_IO_PORT = 32'h0003_0000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Byte count presented to the memory controller for a given access.
    function automatic logic [2:0] access_len(input OP_ENUM_TYPE op);
        case (op)
            LB, LBU, SB: access_len = 3'd1;
            LH, LHU, SH: access_len = 3'd2;
            default:     access_len = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_load_extend                                                      |
// | Sign/zero extension of raw memory read data according to load op.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_load_extend
    import load_store_unit_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
) (
    input  logic [OP_W-1:0]   i_op_enum,
    input  logic [DATA_W-1:0] i_raw_data,
    output logic [DATA_W-1:0] o_ext_data
);

    always_comb begin
        o_ext_data = i_raw_data;
        case (i_op_enum)
            LB:  o_ext_data = {{(DATA_W-8){i_raw_data[7]}}, i_raw_data[7:0]};
            LH:  o_ext_data = {{(DATA_W-16){i_raw_data[15]}}, i_raw_data[15:0]};
            LBU: o_ext_data = {{(DATA_W-8){1'b0}}, i_raw_data[7:0]};
            LHU: o_ext_data = {{(DATA_W-16){1'b0}}, i_raw_data[15:0]};
            default: o_ext_data = i_raw_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit                                                      |
// | One-at-a-time memory access stage between the LSB and memory ctrl.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 5,
    parameter int OP_W     = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                enable_from_lsb,
    input  logic                read_write_flag_from_lsb,
    input  logic [OP_W-1:0]     op_enum_from_lsb,
    input  logic [ADDR_W-1:0]   address_from_lsb,
    input  logic [DATA_W-1:0]   data_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_to_lsb,
    output logic                end_to_lsb,
    output logic [DATA_W-1:0]   data_to_lsb,
    output logic                enable_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic [DATA_W-1:0]   result_to_cdb,
    input  logic                roll_back_flag_from_rob,
    output logic                mem_enable,
    output logic                mem_rw,
    output logic [2:0]          mem_len,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0]          r_state,      w_state;
    logic                r_busy,       w_busy;
    logic                r_end,        w_end;
    logic                r_cdb_en,     w_cdb_en;
    logic                r_discard,    w_discard;
    logic                r_mem_enable, w_mem_enable;
    logic                r_mem_rw,     w_mem_rw;
    logic [2:0]          r_mem_len,    w_mem_len;
    logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
    logic [OP_W-1:0]     r_op,         w_op;
    logic [ROB_ID_W-1:0] r_rob_id,     w_rob_id;
    logic [DATA_W-1:0]   r_rdata,      w_rdata;
    logic [DATA_W-1:0]   w_ext_data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_busy       <= FALSE;
            r_end        <= FALSE;
            r_cdb_en     <= FALSE;
            r_discard    <= FALSE;
            r_mem_enable <= FALSE;
            r_mem_rw     <= READ_SIT;
            r_mem_len    <= 3'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_op         <= '0;
            r_rob_id     <= ROB_ID_TYPE'(ROB_ID_RESET);
            r_rdata      <= '0;
        end else if (rdy_in) begin
            r_state      <= w_state;
            r_busy       <= w_busy;
            r_end        <= w_end;
            r_cdb_en     <= w_cdb_en;
            r_discard    <= w_discard;
            r_mem_enable <= w_mem_enable;
            r_mem_rw     <= w_mem_rw;
            r_mem_len    <= w_mem_len;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_op         <= w_op;
            r_rob_id     <= w_rob_id;
            r_rdata      <= w_rdata;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_busy       = r_busy;
        w_end        = FALSE;
        w_cdb_en     = FALSE;
        w_discard    = r_discard;
        w_mem_enable = r_mem_enable;
        w_mem_rw     = r_mem_rw;
        w_mem_len    = r_mem_len;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_op         = r_op;
        w_rob_id     = r_rob_id;
        w_rdata      = r_rdata;
        case (r_state)
            IDLE: begin
                w_busy = FALSE;
                if (enable_from_lsb) begin
                    w_state      = MEM;
                    w_busy       = TRUE;
                    w_mem_enable = TRUE;
                    w_mem_rw     = read_write_flag_from_lsb;
                    w_mem_len    = access_len(op_enum_from_lsb);
                    w_mem_addr   = address_from_lsb;
                    w_mem_wdata  = data_from_lsb;
                    w_op         = op_enum_from_lsb;
                    w_rob_id     = rob_id_from_lsb;
                    // A load accepted alongside a flush is already squashed.
                    w_discard    = roll_back_flag_from_rob &&
                                   (read_write_flag_from_lsb == READ_SIT);
                end
            end
            MEM: begin
                if (roll_back_flag_from_rob && (r_mem_rw == READ_SIT)) begin
                    w_discard = TRUE;
                end
                if (mem_done) begin
                    w_state      = DONE;
                    w_rdata      = mem_rdata;
                    w_mem_enable = FALSE;
                    w_busy       = FALSE;
                    w_end        = TRUE;
                    w_cdb_en     = (r_mem_rw == READ_SIT) && !w_discard;
                end
            end
            DONE: begin
                w_state   = IDLE;
                w_discard = FALSE;
            end
            default: begin
                w_state      = IDLE;
                w_busy       = FALSE;
                w_discard    = FALSE;
                w_mem_enable = FALSE;
            end
        endcase
    end

    lsu_load_extend #(
        .OP_W   (OP_W),
        .DATA_W (DATA_W)
    ) u_load_extend (
        .i_op_enum  (r_op),
        .i_raw_data (r_rdata),
        .o_ext_data (w_ext_data)
    );

    assign busy_to_lsb   = r_busy;
    assign end_to_lsb    = r_end;
    assign data_to_lsb   = w_ext_data;
    assign enable_to_cdb = r_cdb_en;
    assign rob_id_to_cdb = r_rob_id;
    assign result_to_cdb = w_ext_data;
    assign mem_enable    = r_mem_enable;
    assign mem_rw        = r_mem_rw;
    assign mem_len       = r_mem_len;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire
